jbus_xfer: RTL and testbench

- Bus-transfer initiator for a bank of enable/set byte registers that share one 8-bit bus.
- Accepts a "copy register src -> register dst" request and sequences the per-register enable (we) and set (ws) lines in the required order: enable, set pulse, set falls, enable falls.
- This ordering keeps data stable while it is captured by both latch-based and flop-based register storage.
- Sits between the control/stepper logic and the register bank; it is the driving end of the registers' ws/we interface.

---
 rtl/jbus_xfer_if.sv | 38 +++
 rtl/jbus_xfer.sv | 123 ++++++++++++
 tb/tb_jbus_xfer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/jbus_xfer_if.sv
// Request/handshake and register-bank strobe bundle for jbus_xfer.
// JBUS_XFER_CAPTURE_EN adds the shared bus and the captured data word.
interface jbus_xfer_if #(
    parameter int NREG = 4,
    parameter int IDXW = 2
);
    logic            req_valid;
    logic            req_ready;
    logic [IDXW-1:0] req_src;
    logic [IDXW-1:0] req_dst;
    logic [NREG-1:0] we;
    logic [NREG-1:0] ws;
    logic            busy;
    logic            done;
    logic            err;
`ifdef JBUS_XFER_CAPTURE_EN
    logic [7:0]      bus;
    logic [7:0]      xfer_data;

    modport master (
        output req_valid, req_src, req_dst, bus,
        input  req_ready, we, ws, busy, done, err, xfer_data
    );
    modport slave (
        input  req_valid, req_src, req_dst, bus,
        output req_ready, we, ws, busy, done, err, xfer_data
    );
`else
    modport master (
        output req_valid, req_src, req_dst,
        input  req_ready, we, ws, busy, done, err
    );
    modport slave (
        input  req_valid, req_src, req_dst,
        output req_ready, we, ws, busy, done, err
    );
`endif
endinterface

// File: rtl/jbus_xfer.sv
// Register-to-register bus transfer sequencer: we, ws pulse, ws fall, we fall.
// Optional JBUS_XFER_CAPTURE_EN latches the bus value seen during the set pulse.
module jbus_xfer #(
    parameter int NREG       = 4,
    parameter int IDXW       = 2,
    parameter int SETTLE     = 1,
    parameter int SET_CYCLES = 1
) (
    input logic        clk,
    input logic        reset,
    jbus_xfer_if.slave xif
);
    localparam int MAXC = (SETTLE > SET_CYCLES) ? SETTLE : SET_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, EN, SET, HOLD} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IDXW-1:0] src_q, src_n;
    logic [IDXW-1:0] dst_q, dst_n;
    logic [NREG-1:0] we_q, we_n;
    logic [NREG-1:0] ws_q, ws_n;
    logic            busy_q, done_q, done_n, err_q, err_n;
    logic            accept, bad;

    function automatic logic [NREG-1:0] onehot(input logic [IDXW-1:0] i);
        onehot = {{(NREG-1){1'b0}}, 1'b1} << i;
    endfunction

    assign xif.req_ready = (state == IDLE) && !reset;
    assign accept = xif.req_valid && xif.req_ready;

    // Same-index copy would enable and set one latch, closing a loop.
    assign bad = (32'(xif.req_src) >= 32'(NREG))
              || (32'(xif.req_dst) >= 32'(NREG))
              || (xif.req_src == xif.req_dst);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        src_n   = src_q;
        dst_n   = dst_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    src_n = xif.req_src;
                    dst_n = xif.req_dst;
                    if (bad) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else begin
                        state_n = EN;
                        cnt_n   = CW'(SETTLE - 1);
                    end
                end
            end
            EN: begin
                if (cnt == '0) begin
                    state_n = SET;
                    cnt_n   = CW'(SET_CYCLES - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SET: begin
                if (cnt == '0) state_n = HOLD;
                else           cnt_n   = cnt - 1'b1;
            end
            HOLD: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        endcase
        we_n = (state_n != IDLE) ? onehot(src_n) : '0;
        ws_n = (state_n == SET)  ? onehot(dst_n) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            we_q   <= '0;
            ws_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            src_q  <= src_n;
            dst_q  <= dst_n;
            we_q   <= we_n;
            ws_q   <= ws_n;
            busy_q <= (state_n != IDLE);
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign xif.we   = we_q;
    assign xif.ws   = ws_q;
    assign xif.busy = busy_q;
    assign xif.done = done_q;
    assign xif.err  = err_q;

`ifdef JBUS_XFER_CAPTURE_EN
    logic [7:0] data_q;

    always_ff @(posedge clk) begin
        if (reset)
            data_q <= '0;
        else if (state == SET && cnt == '0)
            data_q <= xif.bus;
    end

    assign xif.xfer_data = data_q;
`endif
endmodule

// File: tb/tb_jbus_xfer.sv
// Directed bench for jbus_xfer: default, long-timing and NREG=3 instances.
// Define JBUS_XFER_CAPTURE_EN to also check the bus capture path.
module tb_jbus_xfer;
    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    jbus_xfer_if #(.NREG(4), .IDXW(2)) x0 ();
    jbus_xfer_if #(.NREG(4), .IDXW(2)) x1 ();
    jbus_xfer_if #(.NREG(3), .IDXW(2)) x2 ();

    jbus_xfer #(.NREG(4), .IDXW(2), .SETTLE(1), .SET_CYCLES(1))
        u0 (.clk(clk), .reset(reset), .xif(x0.slave));
    jbus_xfer #(.NREG(4), .IDXW(2), .SETTLE(2), .SET_CYCLES(3))
        u1 (.clk(clk), .reset(reset), .xif(x1.slave));
    jbus_xfer #(.NREG(3), .IDXW(2), .SETTLE(1), .SET_CYCLES(1))
        u2 (.clk(clk), .reset(reset), .xif(x2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_run++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b1;
        x0.req_valid = 1'b0; x0.req_src = '0; x0.req_dst = '0;
        x1.req_valid = 1'b0; x1.req_src = '0; x1.req_dst = '0;
        x2.req_valid = 1'b0; x2.req_src = '0; x2.req_dst = '0;
`ifdef JBUS_XFER_CAPTURE_EN
        x0.bus = 8'h00; x1.bus = 8'h00; x2.bus = 8'h00;
`endif
        tick();
        tick();
        chk("rst_we",    32'(x0.we), 32'h0);
        chk("rst_ws",    32'(x0.ws), 32'h0);
        chk("rst_busy",  32'(x0.busy), 32'h0);
        chk("rst_done",  32'(x0.done), 32'h0);
        chk("rst_err",   32'(x0.err), 32'h0);
        chk("rst_ready", 32'(x0.req_ready), 32'h0);
`ifdef JBUS_XFER_CAPTURE_EN
        chk("rst_xdata", 32'(x0.xfer_data), 32'h0);
`endif
        reset = 1'b0;
        #1;
        chk("idle_ready", 32'(x0.req_ready), 32'h1);

        // Basic copy 1 -> 3, cycle 0 is the accept cycle.
        x0.req_valid = 1'b1; x0.req_src = 2'd1; x0.req_dst = 2'd3;
        tick();
        x0.req_valid = 1'b0; x0.req_src = 2'd0; x0.req_dst = 2'd0;
        chk("c1_we",    32'(x0.we), 32'h2);
        chk("c1_ws",    32'(x0.ws), 32'h0);
        chk("c1_ready", 32'(x0.req_ready), 32'h0);
        chk("c1_busy",  32'(x0.busy), 32'h1);
`ifdef JBUS_XFER_CAPTURE_EN
        x0.bus = 8'hA5;
`endif
        tick();
        chk("c2_we",    32'(x0.we), 32'h2);
        chk("c2_ws",    32'(x0.ws), 32'h8);
        chk("c2_ready", 32'(x0.req_ready), 32'h0);
        tick();
`ifdef JBUS_XFER_CAPTURE_EN
        x0.bus = 8'h3C;
        chk("c3_xdata", 32'(x0.xfer_data), 32'hA5);
`endif
        chk("c3_we",    32'(x0.we), 32'h2);
        chk("c3_ws",    32'(x0.ws), 32'h0);
        chk("c3_done",  32'(x0.done), 32'h0);
        tick();
        chk("c4_we",    32'(x0.we), 32'h0);
        chk("c4_done",  32'(x0.done), 32'h1);
        chk("c4_err",   32'(x0.err), 32'h0);
        chk("c4_ready", 32'(x0.req_ready), 32'h1);
        chk("c4_busy",  32'(x0.busy), 32'h0);
        tick();
        chk("c5_done",  32'(x0.done), 32'h0);

        // Same src/dst is rejected.
        x0.req_valid = 1'b1; x0.req_src = 2'd2; x0.req_dst = 2'd2;
        tick();
        x0.req_valid = 1'b0;
        chk("rej_we",   32'(x0.we), 32'h0);
        chk("rej_ws",   32'(x0.ws), 32'h0);
        chk("rej_done", 32'(x0.done), 32'h1);
        chk("rej_err",  32'(x0.err), 32'h1);
        chk("rej_busy", 32'(x0.busy), 32'h0);
`ifdef JBUS_XFER_CAPTURE_EN
        chk("rej_xdata", 32'(x0.xfer_data), 32'hA5);
`endif
        tick();
        chk("rej_done2", 32'(x0.done), 32'h0);
        chk("rej_err2",  32'(x0.err), 32'h0);
        chk("rej_we2",   32'(x0.we), 32'h0);

        // Out-of-range dst on the NREG=3 instance.
        x2.req_valid = 1'b1; x2.req_src = 2'd0; x2.req_dst = 2'd3;
        tick();
        x2.req_valid = 1'b0;
        chk("oor_we",   32'(x2.we), 32'h0);
        chk("oor_ws",   32'(x2.ws), 32'h0);
        chk("oor_done", 32'(x2.done), 32'h1);
        chk("oor_err",  32'(x2.err), 32'h1);

        // SETTLE=2, SET_CYCLES=3: we 1-6, ws 3-5, done 7.
        x1.req_valid = 1'b1; x1.req_src = 2'd0; x1.req_dst = 2'd2;
        tick();
        x1.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("long_we_c%0d", c), 32'(x1.we),
                (c <= 6) ? 32'h1 : 32'h0);
            chk($sformatf("long_ws_c%0d", c), 32'(x1.ws),
                (c >= 3 && c <= 5) ? 32'h4 : 32'h0);
            chk($sformatf("long_done_c%0d", c), 32'(x1.done),
                (c == 7) ? 32'h1 : 32'h0);
            tick();
        end

        // Back-to-back with req_valid held high.
        x0.req_valid = 1'b1; x0.req_src = 2'd0; x0.req_dst = 2'd1;
        tick();
        x0.req_src = 2'd1; x0.req_dst = 2'd0;
        chk("b2b_c1_we", 32'(x0.we), 32'h1);
        tick();
        chk("b2b_c2_ws", 32'(x0.ws), 32'h2);
        tick();
        chk("b2b_c3_we", 32'(x0.we), 32'h1);
        tick();
        chk("b2b_c4_we",    32'(x0.we), 32'h0);
        chk("b2b_c4_ws",    32'(x0.ws), 32'h0);
        chk("b2b_c4_done",  32'(x0.done), 32'h1);
        chk("b2b_c4_ready", 32'(x0.req_ready), 32'h1);
        tick();
        x0.req_valid = 1'b0;
        chk("b2b_c5_we",   32'(x0.we), 32'h2);
        chk("b2b_c5_done", 32'(x0.done), 32'h0);
        tick();
        chk("b2b_c6_ws", 32'(x0.ws), 32'h1);
        tick();
        tick();
        chk("b2b_c8_done", 32'(x0.done), 32'h1);
        tick();

        // Reset during the set pulse aborts without done.
        x0.req_valid = 1'b1; x0.req_src = 2'd1; x0.req_dst = 2'd3;
        tick();
        x0.req_valid = 1'b0;
        tick();
        chk("ab_c2_ws", 32'(x0.ws), 32'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("ab_c3_we",    32'(x0.we), 32'h0);
        chk("ab_c3_ws",    32'(x0.ws), 32'h0);
        chk("ab_c3_busy",  32'(x0.busy), 32'h0);
        chk("ab_c3_ready", 32'(x0.req_ready), 32'h1);
        chk("ab_c3_done",  32'(x0.done), 32'h0);
        for (int c = 4; c <= 7; c++) begin
            tick();
            chk($sformatf("ab_done_c%0d", c), 32'(x0.done), 32'h0);
            chk($sformatf("ab_we_c%0d", c), 32'(x0.we), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
